// File: rtl/beep_sequencer_if.sv
// Event and beep-status bundle between the run controller and beep_sequencer.
interface beep_sequencer_if;
    logic click;
    logic hadFinish;
    logic beeLED;
    logic busy;

    modport master (
        output click,
        output hadFinish,
        input  beeLED,
        input  busy
    );

    modport slave (
        input  click,
        input  hadFinish,
        output beeLED,
        output busy
    );
endinterface

// File: rtl/beep_sequencer.sv
// Click and wash-finish beep pattern generator with registered buzzer outputs.
// Click beeps exist only when BEEP_CLICK_BEEP_EN is defined; otherwise only finish patterns sound.
module beep_sequencer #(
    parameter int unsigned TICK_DIV       = 1000,
    parameter int unsigned CLICK_TICKS    = 50,
    parameter int unsigned BEEP_ON_TICKS  = 200,
    parameter int unsigned BEEP_OFF_TICKS = 200,
    parameter int unsigned FINISH_BEEPS   = 3
) (
    input logic             cp,
    input logic             resetBtn,
    beep_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
`ifdef BEEP_CLICK_BEEP_EN
    localparam logic [1:0] CLICK_ON = 2'd1;
`endif
    localparam logic [1:0] FIN_ON   = 2'd2;
    localparam logic [1:0] FIN_OFF  = 2'd3;

    logic [1:0]  stateQ, stateD;
    logic [15:0] preQ, preD;
    logic [7:0]  phaseQ, phaseD;
    logic [3:0]  beepsQ, beepsD;
    logic        finPrevQ;
    logic        finEvent;
    logic        tick;
    logic        ledD;
    logic        beeLEDQ, busyQ;

    assign finEvent = bus.hadFinish & ~finPrevQ;
    assign tick     = (preQ == 16'(TICK_DIV - 1));

`ifdef BEEP_CLICK_BEEP_EN
    logic clickPrevQ;
    logic clickEvent;

    assign clickEvent = bus.click & ~clickPrevQ;

    // Tracks the input during reset too, so a level held across release is not an event.
    always_ff @(posedge cp) begin
        clickPrevQ <= bus.click;
    end
`endif

    always_comb begin
        stateD = stateQ;
        preD   = preQ;
        phaseD = phaseQ;
        beepsD = beepsQ;
        if (stateQ != IDLE) begin
            preD   = tick ? '0 : preQ + 16'd1;
            phaseD = tick ? phaseQ + 8'd1 : phaseQ;
        end

        // A finish event overrides any click and restarts the pattern from any state.
        if (finEvent) begin
            stateD = FIN_ON;
            beepsD = 4'(FINISH_BEEPS);
            preD   = '0;
            phaseD = '0;
        end else begin
            case (stateQ)
                IDLE: begin
`ifdef BEEP_CLICK_BEEP_EN
                    if (clickEvent) begin
                        stateD = CLICK_ON;
                        preD   = '0;
                        phaseD = '0;
                    end
`endif
                end
`ifdef BEEP_CLICK_BEEP_EN
                CLICK_ON: begin
                    if (clickEvent) begin
                        preD   = '0;
                        phaseD = '0;
                    end else if (tick && phaseQ == 8'(CLICK_TICKS - 1)) begin
                        stateD = IDLE;
                        preD   = '0;
                        phaseD = '0;
                    end
                end
`endif
                FIN_ON: begin
                    if (tick && phaseQ == 8'(BEEP_ON_TICKS - 1)) begin
                        beepsD = beepsQ - 4'd1;
                        stateD = (beepsQ == 4'd1) ? IDLE : FIN_OFF;
                        preD   = '0;
                        phaseD = '0;
                    end
                end
                FIN_OFF: begin
                    if (tick && phaseQ == 8'(BEEP_OFF_TICKS - 1)) begin
                        stateD = FIN_ON;
                        preD   = '0;
                        phaseD = '0;
                    end
                end
                default: begin
                    stateD = IDLE;
                    preD   = '0;
                    phaseD = '0;
                    beepsD = '0;
                end
            endcase
        end

`ifdef BEEP_CLICK_BEEP_EN
        ledD = (stateD == FIN_ON) || (stateD == CLICK_ON);
`else
        ledD = (stateD == FIN_ON);
`endif
    end

    always_ff @(posedge cp) begin
        finPrevQ <= bus.hadFinish;
        if (resetBtn) begin
            stateQ  <= IDLE;
            preQ    <= '0;
            phaseQ  <= '0;
            beepsQ  <= '0;
            beeLEDQ <= 1'b0;
            busyQ   <= 1'b0;
        end else begin
            stateQ  <= stateD;
            preQ    <= preD;
            phaseQ  <= phaseD;
            beepsQ  <= beepsD;
            beeLEDQ <= ledD;
            busyQ   <= (stateD != IDLE);
        end
    end

    assign bus.beeLED = beeLEDQ;
    assign bus.busy   = busyQ;
endmodule

// File: tb/tb_beep_sequencer.sv
// Directed scoreboard bench for beep_sequencer with TICK_DIV=4, 1/2/2-tick beeps, 3 finish beeps.
// Expectations follow the BEEP_CLICK_BEEP_EN setting of the build.
module tb_beep_sequencer;
    logic cp = 1'b0;
    logic resetBtn = 1'b1;

    beep_sequencer_if bus ();

    beep_sequencer #(
        .TICK_DIV      (4),
        .CLICK_TICKS   (1),
        .BEEP_ON_TICKS (2),
        .BEEP_OFF_TICKS(2),
        .FINISH_BEEPS  (3)
    ) dut (
        .cp      (cp),
        .resetBtn(resetBtn),
        .bus     (bus.slave)
    );

    always #5 cp = ~cp;

    typedef struct {
        int   cyc;
        logic led;
        logic busy;
    } expT;

    expT sbQ[$];
    int  testsRun = 0;
    int  testsFailed = 0;

    function automatic bit inR(int c, int lo, int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Three 8-cycle beeps separated by 8-cycle gaps, first beep starting at cycle s.
    function automatic bit finLed(int c, int s);
        return inR(c, s, s + 7) || inR(c, s + 16, s + 23) || inR(c, s + 32, s + 39);
    endfunction

    function automatic bit finBusy(int c, int s);
        return inR(c, s, s + 39);
    endfunction

    task automatic pushExp(int c, bit led, bit busy);
        expT e;
        e.cyc  = c;
        e.led  = led;
        e.busy = busy;
        sbQ.push_back(e);
    endtask

    task automatic checkNow(string tag);
        expT e;
        @(negedge cp);
        e = sbQ.pop_front();
        testsRun++;
        assert ({bus.beeLED, bus.busy} === {e.led, e.busy}) else begin
            testsFailed++;
            $error("FAIL %s cyc %0d: beeLED=%b busy=%b, expected beeLED=%b busy=%b",
                   tag, e.cyc, bus.beeLED, bus.busy, e.led, e.busy);
        end
    endtask

    task automatic nextCycle();
        @(posedge cp);
        #1;
    endtask

    // Holds reset for two edges, checks the reset outputs, then releases; cycle 0 follows.
    task automatic startScenario(string tag);
        nextCycle();
        resetBtn = 1'b1;
        bus.click = 1'b0;
        bus.hadFinish = 1'b0;
        nextCycle();
        pushExp(-1, 1'b0, 1'b0);
        checkNow({tag, "_reset"});
        nextCycle();
        resetBtn = 1'b0;
    endtask

    initial begin
        bus.click = 1'b0;
        bus.hadFinish = 1'b0;

        // Single click held for 20 cycles.
        startScenario("click");
        for (int c = 1; c <= 40; c++) begin
            nextCycle();
            bus.click = (c >= 10) && (c < 30);
`ifdef BEEP_CLICK_BEEP_EN
            pushExp(c, inR(c, 11, 14), inR(c, 11, 14));
`else
            pushExp(c, 1'b0, 1'b0);
`endif
            checkNow("click");
        end

        // Finish pattern with hadFinish held high afterwards.
        startScenario("finish");
        for (int c = 1; c <= 60; c++) begin
            nextCycle();
            bus.hadFinish = (c >= 10);
            pushExp(c, finLed(c, 11), finBusy(c, 11));
            checkNow("finish");
        end

        // Click aborted by finish; later click inside FIN_ON is discarded.
        startScenario("abort");
        for (int c = 1; c <= 60; c++) begin
            nextCycle();
            bus.click = (c == 10) || (c == 20);
            bus.hadFinish = (c >= 12);
`ifdef BEEP_CLICK_BEEP_EN
            pushExp(c, inR(c, 11, 12) || finLed(c, 13), inR(c, 11, 12) || finBusy(c, 13));
`else
            pushExp(c, finLed(c, 13), finBusy(c, 13));
`endif
            checkNow("abort");
        end

        // Reset pulse mid-pattern while hadFinish stays high.
        startScenario("midreset");
        for (int c = 1; c <= 60; c++) begin
            nextCycle();
            bus.hadFinish = (c >= 10);
            resetBtn = (c == 30);
            pushExp(c, (c <= 30) && finLed(c, 11), (c <= 30) && finBusy(c, 11));
            checkNow("midreset");
        end

`ifdef BEEP_CLICK_BEEP_EN
        // Click retrigger restarts the length; simultaneous click+finish is a finish.
        startScenario("retrig");
        for (int c = 1; c <= 75; c++) begin
            nextCycle();
            bus.click = (c == 10) || (c == 13) || (c == 30);
            bus.hadFinish = (c >= 30);
            pushExp(c, inR(c, 11, 17) || finLed(c, 31), inR(c, 11, 17) || finBusy(c, 31));
            checkNow("retrig");
        end
`else
        // Click toggled five times is ignored; finish still sounds normally.
        startScenario("noclick");
        for (int c = 1; c <= 70; c++) begin
            nextCycle();
            bus.click = (c >= 10) && (c < 20) && (c % 2 == 0);
            bus.hadFinish = (c >= 25);
            pushExp(c, finLed(c, 26), finBusy(c, 26));
            checkNow("noclick");
        end
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/beep_sequencer.md
BEEP_SEQUENCER -- requirements
Module: beep_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 1000: cp cycles per beep time-unit (tick), legal range 1..65535.
REQ-002 Parameter CLICK_TICKS, default 50: beep length in ticks for one click, legal range 1..255.
REQ-003 Parameter BEEP_ON_TICKS, default 200: on-length in ticks of each finish beep, legal range 1..255.
REQ-004 Parameter BEEP_OFF_TICKS, default 200: gap in ticks between finish beeps, legal range 1..255.
REQ-005 Parameter FINISH_BEEPS, default 3: number of beeps in the finish pattern, legal range 1..15.
REQ-006 cp  input  1  system clock; the single clock; all state changes on its rising edge.
REQ-007 resetBtn  input  1  reset; synchronous, active-high.
REQ-008 click  input  1  synchronized key-click level; each rising edge is one click event.
REQ-009 hadFinish  input  1  wash-complete level from the run controller; each rising edge is one finish event.
REQ-010 beeLED  output  1  buzzer/LED drive, registered.
REQ-011 busy  output  1  high while any pattern is in progress, registered.

Function
REQ-012 The block SHALL hold one previous-value register per event input; an event is detected in the cycle where the input is 1 and its previous value is 0.
REQ-013 The FSM SHALL have exactly four states: IDLE, CLICK_ON, FIN_ON and FIN_OFF.
REQ-014 In IDLE with a finish event, the FSM SHALL go to FIN_ON, set the beep counter to FINISH_BEEPS and clear the tick prescaler.
REQ-015 In IDLE with a click event and no finish event, the FSM SHALL go to CLICK_ON and clear the tick prescaler.
REQ-016 beeLED SHALL be 1 in CLICK_ON and FIN_ON, and 0 in IDLE and FIN_OFF; busy SHALL be 1 in every state except IDLE.
REQ-017 beeLED and busy SHALL first go high in the cycle after the event is detected (one-cycle latency).
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; the cycle in which it wraps is one tick; a phase counter SHALL count ticks within the current state.
REQ-019 CLICK_ON SHALL last exactly CLICK_TICKS*TICK_DIV cycles, then the FSM SHALL return to IDLE.
REQ-020 FIN_ON SHALL last BEEP_ON_TICKS*TICK_DIV cycles and then decrement the beep counter.
REQ-021 After FIN_ON, if the decremented count is 0 the FSM SHALL go to IDLE; otherwise it SHALL go to FIN_OFF.
REQ-022 FIN_OFF SHALL last BEEP_OFF_TICKS*TICK_DIV cycles and then return to FIN_ON.
REQ-023 Each state transition SHALL clear the prescaler and the phase counter.
REQ-024 A finish event in CLICK_ON SHALL abort the click and enter FIN_ON on the next cycle with the full FINISH_BEEPS count.
REQ-025 Click events in FIN_ON or FIN_OFF SHALL be discarded, not queued.
REQ-026 A finish event in FIN_ON or FIN_OFF SHALL restart the pattern: enter FIN_ON, reload the count, clear the counters.
REQ-027 Simultaneous click and finish events SHALL be treated as a finish event only.
REQ-028 A click event in CLICK_ON SHALL restart the click length from zero.
REQ-029 Levels that stay high SHALL NOT create repeated events.

Reset
REQ-030 While resetBtn=1 the block SHALL go to IDLE, and clear the prescaler, phase counter and beep counter.
REQ-031 While resetBtn=1, beeLED and busy SHALL be driven to 0.
REQ-032 While resetBtn=1, each previous-value register SHALL load its current input value, so that an input already high at reset release creates no event.
REQ-033 Reset asserted mid-pattern SHALL take priority over all events and SHALL drop beeLED to 0 on the next edge.

Configuration
REQ-034 With macro BEEP_CLICK_BEEP_EN defined, click events SHALL behave as in REQ-015, REQ-024, REQ-027 and REQ-028.
REQ-035 With BEEP_CLICK_BEEP_EN undefined, the click input SHALL be ignored, CLICK_ON SHALL not be implemented, and only finish patterns SHALL sound.

Verification (TICK_DIV=4, CLICK_TICKS=1, BEEP_ON_TICKS=2, BEEP_OFF_TICKS=2, FINISH_BEEPS=3, macro defined unless stated)
REQ-036 Click rises at cycle 10 and is held for 20 cycles -> beeLED=1 in cycles 11..14 only; busy matches beeLED; exactly one beep.
REQ-037 hadFinish rises at cycle 10 -> beeLED high in 11..18, 27..34 and 43..50, low in between; busy high 11..50; IDLE from cycle 51.
REQ-038 Click at cycle 10, then hadFinish rises at cycle 12 -> click aborted, finish pattern starts at cycle 13 with 3 full beeps; a click at cycle 20 has no effect.
REQ-039 resetBtn pulsed for cycle 30 during the finish pattern -> beeLED=0 and busy=0 from cycle 31; hadFinish still high gives no new pattern.
REQ-040 Macro undefined, click toggled 5 times -> beeLED stays 0; hadFinish edge -> normal 3-beep pattern.
